uart_tx_port: RTL and testbench
===============================

UART_TX_PORT -- requirements
Module: uart_tx_port

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 434, giving clocks per serial bit; legal values 2..65535.
REQ-002 SHALL have parameter DEPTH, default 8, giving transmit FIFO entries; power of two, 2..16.
REQ-003 SHALL have parameters DATA_ADDR 32'h0000_0404, STAT_ADDR 32'h0000_0408 and CTRL_ADDR 32'h0000_0410 as word addresses.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clock  input  1  rising-edge system clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 access_addr  input  32  CPU data-memory address.
REQ-007 w_data  input  32  CPU store data (rs2).
REQ-008 w_en  input  1  CPU store strobe, one clock per store.
REQ-009 r_data  output  32  register read data for access_addr.
REQ-010 tx  output  1  serial line, 8N1, idle high.
REQ-011 int_req  output  1  level interrupt request.

Function
REQ-012 SHALL, on w_en=1 with access_addr=DATA_ADDR and FIFO not full, push w_data[7:0] at that edge; w_data[31:8] are ignored.
REQ-013 SHALL, on a DATA_ADDR write with FIFO full and no pop that cycle, drop the byte and set sticky ovf.
REQ-014 SHALL accept a push when the FIFO is full and a pop occurs in the same cycle; count is unchanged.
REQ-015 SHALL clear ovf on a STAT_ADDR write with w_data[3]=1; a clear in the same cycle as a new overflow leaves ovf=1.
REQ-016 SHALL store CTRL_ADDR writes as ie=w_data[0]; other bits read as 0.
REQ-017 SHALL drive r_data combinationally: STAT_ADDR -> {23'b0, count[4:0], ovf, empty, full, busy} in bits [8:0]; CTRL_ADDR -> {31'b0, ie}; any other address -> 0.
REQ-018 busy SHALL be 1 whenever the FSM is not IDLE or the FIFO is non-empty.
REQ-019 Reads SHALL have no side effects.
REQ-020 The serializer FSM SHALL have states IDLE, START, DATA, STOP.
REQ-021 tx SHALL be a register; IDLE and STOP drive 1, START drives 0, DATA drives shift[0].
REQ-022 IDLE -> START: when the FIFO is non-empty, pop the head into shift[7:0], clear baud counter and bit index.
REQ-023 Each START, DATA and STOP bit SHALL last exactly BAUD_DIV clocks, timed by a 16-bit counter that wraps to 0 at BAUD_DIV-1.
REQ-024 START -> DATA after one bit time; DATA sends 8 bits LSB first, shifting right at each bit boundary; DATA -> STOP after bit index 7.
REQ-025 STOP end: if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
REQ-026 A frame SHALL be exactly 10*BAUD_DIV clocks; back-to-back frames SHALL have no gap.
REQ-027 Latency: a byte written to an empty FIFO with FSM IDLE SHALL drive tx low on the second rising edge after the write edge.
REQ-028 int_req SHALL be ie AND empty AND (FSM==IDLE), registered.
REQ-029 FIFO read/write pointers SHALL wrap modulo DEPTH; count ranges 0..DEPTH.

Reset
REQ-030 While reset_n=0: tx=1, FSM=IDLE, FIFO empty (count=0, pointers=0), ovf=0, ie=0, int_req=0, baud counter and bit index 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately (tx=1 asynchronously) and discard all queued bytes.
REQ-032 The first write after reset_n rises SHALL be handled normally with no spurious frame.

Verification
REQ-033 BAUD_DIV=4: write 0x55 to 0x404 -> tx low 2 edges later, then 1,0,1,0,1,0,1,0,1 each held 4 clocks, idle high; frame 40 clocks.
REQ-034 Write 0xA5, 0x3C back-to-back -> second start bit begins immediately after first stop bit; 80 clocks total, bytes decoded in order.
REQ-035 DEPTH=8: 10 writes while first frame starts -> 9 bytes accepted (one popped), 10th dropped, STAT reads full=1, ovf=1; write 0x8 to 0x408 -> ovf=0.
REQ-036 Write 1 to 0x410, send one byte -> int_req=0 during frame, int_req=1 one clock after FSM returns to IDLE; write 0 -> int_req=0.
REQ-037 Pull reset_n low at DATA bit 3 with 2 bytes queued -> tx=1 at once, STAT=0 after release, no further frames.
REQ-038 Read 0x40C and 0x404 -> r_data=0; STAT unchanged by any read.

Source files
------------

// File: rtl/uart_tx_port.sv
// rtl/uart_tx_port.sv - memory-mapped 8N1 UART transmitter with transmit FIFO
module uart_tx_port #(
  parameter int          BAUD_DIV  = 434,
  parameter int          DEPTH     = 8,
  parameter logic [31:0] DATA_ADDR = 32'h0000_0404,
  parameter logic [31:0] STAT_ADDR = 32'h0000_0408,
  parameter logic [31:0] CTRL_ADDR = 32'h0000_0410
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] access_addr,
  input  logic [31:0] w_data,
  input  logic        w_en,
  output logic [31:0] r_data,
  output logic        tx,
  output logic        int_req
);

  localparam int          AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0] LP_BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [4:0]  LP_DEPTH     = 5'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [4:0]    r_count;
  logic          r_ovf;
  logic          r_ie;
  logic [1:0]    r_state;
  logic [7:0]    r_shift;
  logic [15:0]   r_baud;
  logic [2:0]    r_bit;
  logic          r_tx;
  logic          r_int_req;

  logic          w_empty;
  logic          w_full;
  logic          w_busy;
  logic          w_bit_end;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push;
  logic          w_ovf_set;
  logic          w_ovf_clr;
  logic [7:0]    w_head;
  logic          w_unused_data;

  assign w_empty    = (r_count == 5'd0);
  assign w_full     = (r_count == LP_DEPTH);
  assign w_busy     = (r_state != S_IDLE) || !w_empty;
  assign w_bit_end  = (r_baud == LP_BAUD_LAST);
  assign w_head     = r_mem[r_rd_ptr];

  // The serializer takes a byte when leaving IDLE or at the end of a stop bit.
  assign w_pop      = !w_empty &&
                      ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

  // A full FIFO still accepts a byte when the serializer frees a slot this cycle.
  assign w_push_req = w_en && (access_addr == DATA_ADDR);
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_ovf_clr  = w_en && (access_addr == STAT_ADDR) && w_data[3];

  // Only the low byte of a data store is transmitted.
  assign w_unused_data = ^w_data[31:8];

  assign tx      = r_tx;
  assign int_req = r_int_req;

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_data[7:0];
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 5'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag (a new overflow wins over a clear) and interrupt enable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
      r_ie  <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
      if (w_en && (access_addr == CTRL_ADDR)) begin
        r_ie <= w_data[0];
      end
    end
  end

  // Serializer FSM: baud timing, bit index and shift register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_shift <= 8'd0;
      r_baud  <= 16'd0;
      r_bit   <= 3'd0;
    end else begin
      if (r_state != S_IDLE) begin
        r_baud <= w_bit_end ? 16'd0 : r_baud + 16'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift <= w_head;
            r_baud  <= 16'd0;
            r_bit   <= 3'd0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end
        end
        default: begin
          if (w_bit_end) begin
            if (w_pop) begin
              r_shift <= w_head;
              r_bit   <= 3'd0;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  // Line driver: registered from the current state, so tx trails the FSM by one clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tx <= 1'b1;
    end else begin
      case (r_state)
        S_START: r_tx <= 1'b0;
        S_DATA:  r_tx <= r_shift[0];
        default: r_tx <= 1'b1;
      endcase
    end
  end

  // Level interrupt: transmitter fully drained while enabled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_int_req <= 1'b0;
    end else begin
      r_int_req <= r_ie && w_empty && (r_state == S_IDLE);
    end
  end

  // Register read mux; reads never change state.
  always_comb begin
    r_data = 32'd0;
    if (access_addr == STAT_ADDR) begin
      r_data = {23'd0, r_count, r_ovf, w_empty, w_full, w_busy};
    end else if (access_addr == CTRL_ADDR) begin
      r_data = {31'd0, r_ie};
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// tb/tb_uart_tx_port.sv - directed self-checking bench for uart_tx_port
module tb_uart_tx_port;

  localparam logic [31:0] A_DATA = 32'h0000_0404;
  localparam logic [31:0] A_STAT = 32'h0000_0408;
  localparam logic [31:0] A_CTRL = 32'h0000_0410;
  localparam logic [31:0] A_NONE = 32'h0000_040C;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] access_addr = 32'd0;
  logic [31:0] w_data = 32'd0;
  logic        w_en = 1'b0;
  logic [31:0] r_data;
  logic        tx;
  logic        int_req;

  uart_tx_port #(
    .BAUD_DIV (4),
    .DEPTH    (8)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .access_addr (access_addr),
    .w_data      (w_data),
    .w_en        (w_en),
    .r_data      (r_data),
    .tx          (tx),
    .int_req     (int_req)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic tx_hist  [0:4095];
  logic irq_hist [0:4095];
  always @(negedge clock) begin
    if (cyc < 4096) begin
      tx_hist[cyc]  <= tx;
      irq_hist[cyc] <= int_req;
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] exp_bytes [0:15];
  int         n_bytes;

  typedef struct {
    logic        wen;
    logic [31:0] waddr;
    logic [31:0] wdat;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [0:7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, output int edge_cyc);
    access_addr = a;
    w_data      = d;
    w_en        = 1'b1;
    @(posedge clock);
    #1;
    w_en     = 1'b0;
    edge_cyc = cyc;
  endtask

  task automatic chk_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
    access_addr = a;
    #1;
    chk(name, r_data, exp);
  endtask

  // Expected line level k edges after the write edge of the first byte.
  function automatic logic exp_tx(input int k);
    int t, f, pos;
    t = k - 2;
    if (t < 0) return 1'b1;
    f = t / 40;
    if (f >= n_bytes) return 1'b1;
    pos = (t % 40) / 4;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return exp_bytes[f][pos-1];
  endfunction

  task automatic check_frames(input string name, input int c0);
    int last;
    int errs;
    last = c0 + n_bytes * 40 + 3;
    while (cyc <= last) tick(1);
    errs = 0;
    for (int k = 1; k <= n_bytes * 40 + 3; k++) begin
      if (tx_hist[c0 + k] !== exp_tx(k)) errs++;
    end
    chk(name, errs, 0);
  endtask

  initial begin
    int c0, c1, cw, rel, errs;

    reset_n = 1'b0;
    tick(3);
    chk("reset tx", {31'd0, tx}, 32'd1);
    chk("reset int_req", {31'd0, int_req}, 32'd0);
    chk_reg("reset stat", A_STAT, 32'h4);
    reset_n = 1'b1;
    tick(1);

    vt[0] = '{1'b0, 32'd0,  32'd0,          A_STAT, 32'h4};
    vt[1] = '{1'b0, 32'd0,  32'd0,          A_CTRL, 32'h0};
    vt[2] = '{1'b0, 32'd0,  32'd0,          A_NONE, 32'h0};
    vt[3] = '{1'b0, 32'd0,  32'd0,          A_DATA, 32'h0};
    vt[4] = '{1'b1, A_CTRL, 32'hFFFF_FFFF,  A_CTRL, 32'h1};
    vt[5] = '{1'b1, A_CTRL, 32'h0000_0002,  A_CTRL, 32'h0};
    vt[6] = '{1'b1, A_STAT, 32'h0000_0008,  A_STAT, 32'h4};
    vt[7] = '{1'b1, A_NONE, 32'h0000_00FF,  A_STAT, 32'h4};
    for (int i = 0; i < 8; i++) begin
      if (vt[i].wen) wr(vt[i].waddr, vt[i].wdat, c0);
      chk_reg($sformatf("vec%0d", i), vt[i].raddr, vt[i].exp);
      tick(1);
    end

    // Single 0x55 frame with start-bit latency and idle tail.
    exp_bytes[0] = 8'h55;
    n_bytes = 1;
    wr(A_DATA, 32'h0000_0055, c0);
    check_frames("frame 0x55", c0);
    chk("tx still high 1 edge after write", {31'd0, tx_hist[c0 + 1]}, 32'd1);
    chk("tx low 2 edges after write", {31'd0, tx_hist[c0 + 2]}, 32'd0);
    tick(2);

    // Back-to-back frames with no gap.
    exp_bytes[0] = 8'hA5;
    exp_bytes[1] = 8'h3C;
    n_bytes = 2;
    wr(A_DATA, 32'h0000_00A5, c0);
    wr(A_DATA, 32'h0000_003C, c1);
    check_frames("frames A5 3C", c0);
    tick(2);

    // Fill past capacity while the first frame starts.
    wr(A_DATA, 32'hDEAD_BE30, c0);
    exp_bytes[0] = 8'h30;
    for (int i = 1; i < 10; i++) begin
      wr(A_DATA, 32'hDEAD_BE00 | 32'(8'h30 + i), c1);
      if (i < 9) exp_bytes[i] = 8'(8'h30 + i);
    end
    n_bytes = 9;
    chk_reg("stat full ovf", A_STAT, 32'h8B);
    wr(A_STAT, 32'h0000_0008, cw);
    chk_reg("stat ovf cleared", A_STAT, 32'h83);
    check_frames("nine queued frames", c0);
    chk_reg("stat drained", A_STAT, 32'h4);
    tick(2);

    // Interrupt follows drain of the transmitter.
    wr(A_CTRL, 32'h1, cw);
    tick(1);
    chk("int_req idle enabled", {31'd0, int_req}, 32'd1);
    exp_bytes[0] = 8'h81;
    n_bytes = 1;
    wr(A_DATA, 32'h0000_0081, c0);
    check_frames("frame 0x81", c0);
    chk("int_req low early frame", {31'd0, irq_hist[c0 + 2]}, 32'd0);
    chk("int_req low mid frame", {31'd0, irq_hist[c0 + 20]}, 32'd0);
    chk("int_req low at idle entry", {31'd0, irq_hist[c0 + 41]}, 32'd0);
    chk("int_req high after idle", {31'd0, irq_hist[c0 + 42]}, 32'd1);
    wr(A_CTRL, 32'h0, cw);
    tick(1);
    chk("int_req disabled", {31'd0, int_req}, 32'd0);
    chk_reg("ctrl disabled", A_CTRL, 32'h0);
    tick(2);

    // Reset during data bit 3 with two bytes queued.
    wr(A_DATA, 32'h0000_00F0, c0);
    wr(A_DATA, 32'h0000_0011, c1);
    wr(A_DATA, 32'h0000_0022, c1);
    while (cyc < c0 + 19) tick(1);
    chk("tx bit3 before reset", {31'd0, tx}, 32'd0);
    reset_n = 1'b0;
    #1;
    chk("tx async high in reset", {31'd0, tx}, 32'd1);
    chk_reg("stat in reset", A_STAT, 32'h4);
    tick(3);
    reset_n = 1'b1;
    rel = cyc;
    tick(60);
    errs = 0;
    for (int k = 0; k < 59; k++) begin
      if (tx_hist[rel + k] !== 1'b1) errs++;
    end
    chk("no frame after reset", errs, 0);
    chk_reg("stat after reset", A_STAT, 32'h4);

    // First write after reset behaves normally.
    exp_bytes[0] = 8'h3C;
    n_bytes = 1;
    wr(A_DATA, 32'h0000_003C, c0);
    check_frames("frame after reset", c0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
